// File: rtl/pdp_exec_unit.sv
// pdp_exec_unit: PDP-8 execution unit (AC/Link/PC, operand memory port); optional EXEC_PERF_CNT_EN adds instr_count
package pdp_exec_pkg;
    typedef struct packed {
        logic NOP, AND, TAD, ISZ, DCA, JMS, JMP;
        logic [11:0] mem_inst_addr;
    } pdp_mem_opcode_s;
    typedef struct packed {
        logic NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CLA, CLL, HLT;
    } pdp_op7_opcode_s;
endpackage

module pdp_exec_unit
    import pdp_exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'o200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] PC_value,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  pdp_mem_opcode_s       pdp_mem_opcode,
    input  pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  exec_rd_req,
    output logic [ADDR_WIDTH-1:0] exec_rd_addr,
    input  logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_wr_req,
    output logic [ADDR_WIDTH-1:0] exec_wr_addr,
    output logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic                  link_out,
`ifdef EXEC_PERF_CNT_EN
    output logic [31:0]           instr_count,
`endif
    output logic                  halted
);
    typedef enum logic [2:0] {IDLE, DECODE, MEM_RD, MEM_WAIT, WRITE, EXEC, RETIRE, HALT} state_e;
    localparam int AND = 5, TAD = 4, ISZ = 3, DCA = 2, JMS = 1, JMP = 0;
    localparam int IAC = 9, RAL = 8, RTL = 7, RAR = 6, RTR = 5, CML = 4, CMA = 3, CLA = 2, CLL = 1, HLT = 0;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1, TWO_A = 2;
    localparam logic [DATA_WIDTH-1:0] ONE_D = 1;
    localparam logic [DATA_WIDTH:0] ONE_R = 1;

    state_e state_q, state_d;
    logic stall_q, stall_d, l_q, l_d, halted_q, halted_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, ea_q, ea_d, base_q, base_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d, m_q, m_d;
    logic [5:0] mem_q, mem_d, mem_in;
    logic [9:0] op7_q, op7_d, op7_in;
    logic [DATA_WIDTH:0] r;
    logic in_valid;

    // NOP bits only count toward validity; a NOP retires like an empty opcode
    assign mem_in = {pdp_mem_opcode.AND, pdp_mem_opcode.TAD, pdp_mem_opcode.ISZ,
                     pdp_mem_opcode.DCA, pdp_mem_opcode.JMS, pdp_mem_opcode.JMP};
    assign op7_in = {pdp_op7_opcode.IAC, pdp_op7_opcode.RAL, pdp_op7_opcode.RTL, pdp_op7_opcode.RAR,
                     pdp_op7_opcode.RTR, pdp_op7_opcode.CML, pdp_op7_opcode.CMA, pdp_op7_opcode.CLA,
                     pdp_op7_opcode.CLL, pdp_op7_opcode.HLT};
    assign in_valid = pdp_mem_opcode.NOP || |mem_in || pdp_op7_opcode.NOP || |op7_in;

    assign stall        = stall_q;
    assign PC_value     = pc_q;
    assign ac_out       = ac_q;
    assign link_out     = l_q;
    assign halted       = halted_q;
    assign exec_rd_req  = state_q == MEM_RD && !reset_n;
    assign exec_rd_addr = exec_rd_req ? ea_q : '0;
    assign exec_wr_req  = state_q == WRITE && !reset_n;
    assign exec_wr_addr = exec_wr_req ? ea_q : '0;
    assign exec_wr_data = !exec_wr_req ? '0 : mem_q[DCA] ? ac_q :
                          mem_q[JMS] ? DATA_WIDTH'(base_q + ONE_A) : m_q;

    // next-state logic; op7 work is evaluated every cycle and only committed in EXEC
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ac_d     = ac_q;
        l_d      = l_q;
        halted_d = halted_q;
        mem_d    = mem_q;
        op7_d    = op7_q;
        ea_d     = ea_q;
        base_d   = base_q;
        m_d      = m_q;
        r = {op7_q[CLL] ? 1'b0 : l_q, op7_q[CLA] ? '0 : ac_q};
        r = r ^ {op7_q[CML], {DATA_WIDTH{op7_q[CMA]}}};
        r = op7_q[IAC] ? r + ONE_R : r;
        r = op7_q[RAR] ? {r[0], r[DATA_WIDTH:1]} :
            op7_q[RAL] ? {r[DATA_WIDTH-1:0], r[DATA_WIDTH]} :
            op7_q[RTR] ? {r[1:0], r[DATA_WIDTH:2]} :
            op7_q[RTL] ? {r[DATA_WIDTH-2:0], r[DATA_WIDTH:DATA_WIDTH-1]} : r;
        case (state_q)
            IDLE: if (!stall_q && in_valid) begin
                state_d = DECODE;
                base_d  = base_addr;
                ea_d    = ADDR_WIDTH'(pdp_mem_opcode.mem_inst_addr);
                mem_d   = $onehot(mem_in) && !pdp_mem_opcode.NOP ? mem_in : '0;
                op7_d   = pdp_mem_opcode.NOP || |mem_in ? '0 : op7_in;
            end
            DECODE: state_d = |mem_q[AND:ISZ] ? MEM_RD : |mem_q[DCA:JMS] ? WRITE : |op7_q ? EXEC : RETIRE;
            MEM_RD: state_d = MEM_WAIT;
            MEM_WAIT: begin
                m_d = exec_rd_data + (mem_q[ISZ] ? ONE_D : '0);
                ac_d = mem_q[AND] ? ac_q & exec_rd_data : ac_q;
                if (mem_q[TAD]) {l_d, ac_d} = {l_q, ac_q} + {1'b0, exec_rd_data};
                state_d = mem_q[ISZ] ? WRITE : RETIRE;
            end
            WRITE: begin
                ac_d    = mem_q[DCA] ? '0 : ac_q;
                state_d = RETIRE;
            end
            EXEC: begin
                {l_d, ac_d} = r;
                halted_d    = op7_q[HLT];
                pc_d        = op7_q[HLT] ? pc_q : base_q + ONE_A;
                state_d     = op7_q[HLT] ? HALT : IDLE;
            end
            RETIRE: begin
                pc_d = mem_q[JMP] ? ea_q : mem_q[JMS] ? ea_q + ONE_A :
                       base_q + (mem_q[ISZ] && m_q == '0 ? TWO_A : ONE_A);
                state_d = IDLE;
            end
            default: state_d = HALT;
        endcase
        stall_d = state_d != IDLE;
    end

    // state and architectural registers
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            stall_q  <= 1'b1;
            pc_q     <= START_ADDR;
            ac_q     <= '0;
            l_q      <= 1'b0;
            halted_q <= 1'b0;
            mem_q    <= '0;
            op7_q    <= '0;
            ea_q     <= '0;
            base_q   <= '0;
            m_q      <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            pc_q     <= pc_d;
            ac_q     <= ac_d;
            l_q      <= l_d;
            halted_q <= halted_d;
            mem_q    <= mem_d;
            op7_q    <= op7_d;
            ea_q     <= ea_d;
            base_q   <= base_d;
            m_q      <= m_d;
        end
    end

`ifdef EXEC_PERF_CNT_EN
    logic [31:0] cnt_q;
    assign instr_count = cnt_q;
    // saturating count of retired instructions, HLT included
    always_ff @(posedge clk) begin
        if (reset_n) cnt_q <= '0;
        else cnt_q <= cnt_q + {31'd0, (state_q == RETIRE || state_q == EXEC) && ~&cnt_q};
    end
`endif
endmodule

// File: tb/tb_pdp_exec_unit.sv
// tb_pdp_exec_unit: directed-vector bench for pdp_exec_unit with a one-word operand memory model
module tb_pdp_exec_unit;
    import pdp_exec_pkg::*;

    localparam logic [6:0] M_AND = 7'b0100000, M_TAD = 7'b0010000, M_ISZ = 7'b0001000,
                           M_DCA = 7'b0000100, M_JMS = 7'b0000010, M_JMP = 7'b0000001;
    localparam logic [10:0] O_IAC = 11'h200, O_RAL = 11'h100, O_RTR = 11'h020,
                            O_CMA = 11'h008, O_CLA = 11'h004, O_CLL = 11'h002, O_HLT = 11'h001;

    logic clk = 0, reset_n = 1;
    logic stall, exec_rd_req, exec_wr_req, link_out, halted;
    logic [11:0] PC_value, base_addr, exec_rd_addr, exec_rd_data, exec_wr_addr, exec_wr_data, ac_out;
    pdp_mem_opcode_s mem_op;
    pdp_op7_opcode_s op7;
`ifdef EXEC_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    int checks = 0, errors = 0;
    int rd_n = 0, wr_n = 0, both_n = 0, drd, dwr;
    logic [11:0] m_val = 0, rd_a = 0, wr_a = 0, wr_d = 0;

    pdp_exec_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .PC_value(PC_value), .base_addr(base_addr),
        .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7),
        .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
        .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
        .ac_out(ac_out), .link_out(link_out),
`ifdef EXEC_PERF_CNT_EN
        .instr_count(instr_count),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    // memory model: returns m_val one cycle after a read, records traffic
    always @(posedge clk) begin
        exec_rd_data <= exec_rd_req ? m_val : 12'd0;
        if (exec_rd_req) begin
            rd_n <= rd_n + 1;
            rd_a <= exec_rd_addr;
        end
        if (exec_wr_req) begin
            wr_n <= wr_n + 1;
            wr_a <= exec_wr_addr;
            wr_d <= exec_wr_data;
        end
        if (exec_rd_req && exec_wr_req) both_n <= both_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0o exp %0o", tag, got, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [6:0] m, input logic [11:0] ea,
                         input logic [10:0] o, input logic [11:0] base, input int lat);
        int n, r0, w0;
        n = 0;
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        r0 = rd_n;
        w0 = wr_n;
        mem_op = {m, ea};
        op7 = o;
        base_addr = base;
        @(negedge clk);
        mem_op = '0;
        op7 = '0;
        n = 1;
        while (stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        drd = rd_n - r0;
        dwr = wr_n - w0;
    endtask

    initial begin
        int n;
        logic stuck;
        mem_op = '0;
        op7 = '0;
        base_addr = 0;
        exec_rd_data = 0;
        repeat (3) @(negedge clk);
        check("reset stall", 32'(stall), 1);
        check("reset pc", 32'(PC_value), 'o200);
        check("reset ac", 32'(ac_out), 0);
        check("reset link", 32'(link_out), 0);
        check("reset halted", 32'(halted), 0);
        check("reset rdreq", 32'(exec_rd_req), 0);
        reset_n = 0;
        @(negedge clk);
        check("release stall", 32'(stall), 0);

        issue("op7 cla cll iac", 7'd0, 12'd0, O_CLA | O_CLL | O_IAC, 'o177, 3);
        check("iac ac", 32'(ac_out), 1);
        check("iac pc", 32'(PC_value), 'o200);

        m_val = 'o7777;
        issue("tad", M_TAD, 'o50, 11'd0, 'o200, 5);
        check("tad ac", 32'(ac_out), 0);
        check("tad link", 32'(link_out), 1);
        check("tad pc", 32'(PC_value), 'o201);
        check("tad rd count", 32'(drd), 1);
        check("tad rd addr", 32'(rd_a), 'o50);
        check("tad wr count", 32'(dwr), 0);

        issue("isz skip", M_ISZ, 'o60, 11'd0, 'o300, 6);
        check("isz skip wr count", 32'(dwr), 1);
        check("isz skip wr addr", 32'(wr_a), 'o60);
        check("isz skip wr data", 32'(wr_d), 0);
        check("isz skip pc", 32'(PC_value), 'o302);
        m_val = 5;
        issue("isz", M_ISZ, 'o60, 11'd0, 'o300, 6);
        check("isz wr data", 32'(wr_d), 6);
        check("isz pc", 32'(PC_value), 'o301);
        check("isz rd count", 32'(drd), 1);

        issue("jms", M_JMS, 'o400, 11'd0, 'o210, 4);
        check("jms wr addr", 32'(wr_a), 'o400);
        check("jms wr data", 32'(wr_d), 'o211);
        check("jms pc", 32'(PC_value), 'o401);
        check("jms rd count", 32'(drd), 0);
        issue("jmp", M_JMP, 'o7777, 11'd0, 'o401, 3);
        check("jmp pc", 32'(PC_value), 'o7777);

        issue("cma wrap", 7'd0, 12'd0, O_CMA, 'o7777, 3);
        check("cma ac", 32'(ac_out), 'o7777);
        check("cma pc wrap", 32'(PC_value), 0);
        issue("dca", M_DCA, 'o70, 11'd0, 0, 4);
        check("dca wr data", 32'(wr_d), 'o7777);
        check("dca wr addr", 32'(wr_a), 'o70);
        check("dca ac", 32'(ac_out), 0);
        check("dca pc", 32'(PC_value), 1);

        issue("cma", 7'd0, 12'd0, O_CMA, 1, 3);
        m_val = 'o1234;
        issue("and", M_AND, 'o100, 11'd0, 2, 5);
        check("and ac", 32'(ac_out), 'o1234);
        check("and pc", 32'(PC_value), 3);

        issue("cla cll iac ral", 7'd0, 12'd0, O_CLA | O_CLL | O_IAC | O_RAL, 3, 3);
        check("ral ac", 32'(ac_out), 2);
        check("ral link", 32'(link_out), 0);
        issue("rtr", 7'd0, 12'd0, O_RTR, 4, 3);
        check("rtr ac", 32'(ac_out), 0);
        check("rtr link", 32'(link_out), 1);
        issue("iac", 7'd0, 12'd0, O_IAC, 5, 3);
        check("iac2 ac", 32'(ac_out), 1);
        check("iac2 link", 32'(link_out), 1);

        issue("multihot", M_TAD | M_JMP, 'o123, 11'd0, 6, 3);
        check("multihot pc", 32'(PC_value), 7);
        check("multihot ac", 32'(ac_out), 1);
        check("multihot rd count", 32'(drd), 0);
        issue("both valid", M_JMP, 'o500, O_CLA, 7, 3);
        check("both pc", 32'(PC_value), 'o500);
        check("both ac", 32'(ac_out), 1);

        m_val = 'o7777;
        issue("tad toggle", M_TAD, 'o51, 11'd0, 'o500, 5);
        check("tad toggle ac", 32'(ac_out), 0);
        check("tad toggle link", 32'(link_out), 0);
        check("tad toggle pc", 32'(PC_value), 'o501);

        op7 = O_HLT;
        base_addr = 'o501;
        @(negedge clk);
        op7 = '0;
        stuck = 1;
        repeat (100) begin
            @(negedge clk);
            if (!stall) stuck = 0;
        end
        check("hlt halted", 32'(halted), 1);
        check("hlt stall held", 32'(stuck), 1);

        reset_n = 1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        check("rst after hlt halted", 32'(halted), 0);
        check("rst after hlt stall", 32'(stall), 0);

        m_val = 0;
        mem_op = {M_ISZ, 12'o60};
        base_addr = 'o300;
        @(negedge clk);
        mem_op = '0;
        n = 0;
        while (!exec_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort rd seen", 32'(exec_rd_req), 1);
        n = wr_n;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        check("abort stall in reset", 32'(stall), 1);
        reset_n = 0;
        repeat (10) @(negedge clk);
        check("abort no write", 32'(wr_n - n), 0);
        check("abort pc", 32'(PC_value), 'o200);
        check("abort stall", 32'(stall), 0);
        check("rd wr overlap", 32'(both_n), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
